game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter HIT_FRAMES, default 30: number of 60 Hz ticks spent frozen in HIT before entering OVER.
REQ-002 Parameter MAX_SPEED, default 7: saturation value of o_speed.
REQ-003 clk  input  1  pixel clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_tick_60hz  input  1  one-cycle frame pulse.
REQ-006 i_tick_20hz  input  1  one-cycle pulse on every third frame; coincides with an i_tick_60hz pulse.
REQ-007 i_collision  input  1  obstacle/player pixel overlap; valid in any cycle.
REQ-008 i_btn  input  1  raw jump/start button, asynchronous to game timing.
REQ-009 o_state  output  2  IDLE=0, RUN=1, HIT=2, OVER=3.
REQ-010 o_running  output  1  high iff o_state==RUN.
REQ-011 o_speed  output  3  scroll speed for obstacle generator.
REQ-012 o_score  output  16  current score, 4-digit BCD.
REQ-013 o_hiscore  output  16  best score since reset, 4-digit BCD.
REQ-014 o_restart  output  1  one-cycle pulse telling world generators to clear.
REQ-015 o_jump  output  1  one-cycle jump request to the player sprite.

Function
REQ-016 i_btn shall pass through a 2-flop synchronizer, then be sampled into btn_s only on i_tick_60hz; press = btn_s rising 0->1, asserted for exactly the one cycle in which btn_s updates.
REQ-017 IDLE: press -> RUN; o_restart=1 in the transition cycle; o_score<=0; o_speed<=1.
REQ-018 RUN: i_collision=1 in any cycle -> HIT next cycle; collision wins over a coincident tick or press.
REQ-019 RUN: press without collision -> o_jump=1 for that cycle only; o_jump is never asserted outside RUN.
REQ-020 RUN: i_tick_20hz without collision -> o_score increments by 1 in BCD, each digit wrapping 9->0 with carry; 9999 wraps to 0000.
REQ-021 RUN: o_speed increments by 1 on each increment that makes the two low BCD digits 00, saturating at MAX_SPEED.
REQ-022 HIT: score and speed frozen; presses ignored; a down-counter loaded with HIT_FRAMES-1 on entry decrements per i_tick_60hz; the tick seen at count 0 -> OVER.
REQ-023 OVER entry cycle: if o_score > o_hiscore (unsigned compare of BCD words), o_hiscore <= o_score.
REQ-024 OVER: press -> RUN with the same actions as REQ-017.
REQ-025 All outputs shall be registered except o_running, o_jump and o_restart, which decode state/press combinationally.
REQ-026 Score/state updates occur on the cycle after the qualifying input; no other latency.

Reset
REQ-027 rst shall put the FSM in IDLE and set o_score=0, o_hiscore=0, o_speed=0, btn_s=0, synchronizer=0 and HIT counter=0.
REQ-028 rst shall hold o_restart and o_jump at 0 while asserted; rst mid-RUN discards score without updating o_hiscore.

Structure
REQ-029 State encodings, the BCD width and the parameter defaults shall live in a shared package, game_pkg.
REQ-030 The 4-digit BCD incrementer shall be one sub-module, bcd_counter4 (inc, clr, value, carry-out of the low two digits).

Verification
REQ-031 Reset, then hold i_btn=1 across 3 frames -> exactly one o_restart pulse, o_state=1, o_speed=1, o_score=0000.
REQ-032 In RUN, 300 i_tick_20hz pulses -> o_score=0300, o_speed=4; preloaded score 9999 plus one tick -> 0000.
REQ-033 In RUN, i_collision and i_tick_20hz in the same cycle -> o_score unchanged, o_state=2 next cycle.
REQ-034 HIT with HIT_FRAMES=30 -> o_state=3 after exactly 30 i_tick_60hz pulses; score 0123 over hiscore 0045 -> o_hiscore=0123.
REQ-035 In OVER, press -> RUN with o_restart pulse, o_score=0000, o_hiscore retained; presses during HIT produce no o_jump or o_restart.
REQ-036 Assert rst mid-RUN at score 0500 -> all outputs at reset values next cycle and o_hiscore=0000.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and defaults for the game controller slice.
package game_pkg;

  localparam int BCD_W          = 16;
  localparam int HIT_FRAMES_DEF = 30;
  localparam int MAX_SPEED_DEF  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle of frame timing, player input and game status signals.
// master drives the world inputs; slave is the game controller.
interface game_ctrl_if
  import game_pkg::*;
  ();

  logic             i_tick_60hz;
  logic             i_tick_20hz;
  logic             i_collision;
  logic             i_btn;
  logic [1:0]       o_state;
  logic             o_running;
  logic [2:0]       o_speed;
  logic [BCD_W-1:0] o_score;
  logic [BCD_W-1:0] o_hiscore;
  logic             o_restart;
  logic             o_jump;

  modport master (
    output i_tick_60hz, i_tick_20hz, i_collision, i_btn,
    input  o_state, o_running, o_speed, o_score, o_hiscore, o_restart, o_jump
  );

  modport slave (
    input  i_tick_60hz, i_tick_20hz, i_collision, i_btn,
    output o_state, o_running, o_speed, o_score, o_hiscore, o_restart, o_jump
  );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter with synchronous clear; 9999 wraps to 0000.
// carry_lo_o flags an increment that rolls the low two digits 99 -> 00.
module bcd_counter4
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [BCD_W-1:0] value_o,
  output logic             carry_lo_o
);

  logic [BCD_W-1:0] value_q, value_d;

  // Ripple the increment through the digits, noting the carry out of digit 1.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    logic c;
    value_d    = value_q;
    carry_lo_o = 1'b0;
    c          = inc_i;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (value_q[4*d +: 4] == 4'd9) begin
          value_d[4*d +: 4] = 4'd0;
        end else begin
          value_d[4*d +: 4] = value_q[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
      if (d == 1) carry_lo_o = c;
    end
    if (clr_i) begin
      value_d    = '0;
      carry_lo_o = 1'b0;
    end
  end

  // Score register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: IDLE -> RUN -> HIT -> OVER, score/speed/hiscore
// bookkeeping and the frame-sampled start/jump button.
module game_ctrl
  import game_pkg::*;
#(
  parameter int HIT_FRAMES = HIT_FRAMES_DEF,
  parameter int MAX_SPEED  = MAX_SPEED_DEF
) (
  input logic        clk,
  input logic        rst,
  game_ctrl_if.slave bus
);

  localparam int CNT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [2:0]       speed_q, speed_d;
  logic [BCD_W-1:0] hiscore_q, hiscore_d;
  logic [BCD_W-1:0] score;
  logic             sync1_q, sync2_q, btn_s_q;
  logic             press, score_inc, score_clr, carry_lo;

  // Synchronise the raw button, then sample it once per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= bus.i_btn;
      sync2_q <= sync1_q;
      if (bus.i_tick_60hz) btn_s_q <= sync2_q;
    end
  end

  // A press is the frame in which btn_s is about to rise; muted during reset.
  assign press = bus.i_tick_60hz & sync2_q & ~btn_s_q & ~rst;

  assign score_clr = press & ((state_q == ST_IDLE) | (state_q == ST_OVER));
  assign score_inc = (state_q == ST_RUN) & ~bus.i_collision & bus.i_tick_20hz;

  bcd_counter4 u_score (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (score_inc),
    .clr_i      (score_clr),
    .value_o    (score),
    .carry_lo_o (carry_lo)
  );

  // Next-state and bookkeeping decode; collision has priority inside RUN.
  always_comb begin
    state_d   = state_q;
    hit_cnt_d = hit_cnt_q;
    speed_d   = speed_q;
    hiscore_d = hiscore_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (press) begin
          state_d = ST_RUN;
          speed_d = 3'd1;
        end
      end
      ST_RUN: begin
        if (bus.i_collision) begin
          state_d   = ST_HIT;
          hit_cnt_d = CNT_W'(HIT_FRAMES - 1);
        end else if (score_inc && carry_lo && (speed_q < 3'(MAX_SPEED))) begin
          speed_d = speed_q + 3'd1;
        end
      end
      ST_HIT: begin
        if (bus.i_tick_60hz) begin
          if (hit_cnt_q == '0) begin
            state_d = ST_OVER;
            if (score > hiscore_q) hiscore_d = score;
          end else begin
            hit_cnt_d = hit_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hit_cnt_q <= '0;
      speed_q   <= 3'd0;
      hiscore_q <= '0;
    end else begin
      state_q   <= state_d;
      hit_cnt_q <= hit_cnt_d;
      speed_q   <= speed_d;
      hiscore_q <= hiscore_d;
    end
  end

  assign bus.o_state   = state_q;
  assign bus.o_running = (state_q == ST_RUN);
  assign bus.o_speed   = speed_q;
  assign bus.o_score   = score;
  assign bus.o_hiscore = hiscore_q;
  assign bus.o_restart = score_clr;
  assign bus.o_jump    = press & (state_q == ST_RUN) & ~bus.i_collision;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with hand-computed expectations.
module tb_game_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   restart_cnt;
  int   jump_cnt;

  always #5 clk = ~clk;

  game_ctrl_if bus ();

  game_ctrl #(.HIT_FRAMES(30), .MAX_SPEED(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // One clock with the given pulses; pulse outputs are tallied mid-cycle.
  task automatic cyc(input logic t60, input logic t20, input logic col);
    bus.i_tick_60hz = t60;
    bus.i_tick_20hz = t20;
    bus.i_collision = col;
    @(negedge clk);
    restart_cnt += int'(bus.o_restart);
    jump_cnt    += int'(bus.o_jump);
    @(posedge clk);
    #1;
    bus.i_tick_60hz = 1'b0;
    bus.i_tick_20hz = 1'b0;
    bus.i_collision = 1'b0;
  endtask

  // Release then press the button, one frame each; the press lands on the last tick.
  task automatic press_frame();
    bus.i_btn = 1'b0;
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    bus.i_btn = 1'b1;
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
  endtask

  // Thirty frozen frames with the button toggling; OVER only after the 30th tick.
  task automatic hit_phase(input logic [15:0] score_exp, input logic [15:0] hi_exp);
    restart_cnt = 0;
    jump_cnt    = 0;
    for (int i = 0; i < 30; i++) begin
      bus.i_btn = i[0];
      repeat (3) cyc(0, 0, 0);
      cyc(1, 1, 0);
      if (i == 28) check("hit_still_at_29", 32'(bus.o_state), 32'd2);
    end
    check("over_after_30", 32'(bus.o_state), 32'd3);
    check("hit_score_frozen", 32'(bus.o_score), 32'(score_exp));
    check("over_hiscore", 32'(bus.o_hiscore), 32'(hi_exp));
    check("hit_no_restart", 32'(restart_cnt), 32'd0);
    check("hit_no_jump", 32'(jump_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_tick_60hz = 1'b0;
    bus.i_tick_20hz = 1'b0;
    bus.i_collision = 1'b0;
    bus.i_btn       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.o_state), 32'd0);
    check("rst_score", 32'(bus.o_score), 32'h0);
    check("rst_hiscore", 32'(bus.o_hiscore), 32'h0);
    check("rst_speed", 32'(bus.o_speed), 32'd0);
    check("rst_running", 32'(bus.o_running), 32'd0);
    rst = 1'b0;

    // Button held across three frames: one start only.
    restart_cnt = 0;
    bus.i_btn   = 1'b1;
    repeat (3) cyc(0, 0, 0);
    repeat (3) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
    end
    check("start_restart_cnt", 32'(restart_cnt), 32'd1);
    check("start_state", 32'(bus.o_state), 32'd1);
    check("start_running", 32'(bus.o_running), 32'd1);
    check("start_speed", 32'(bus.o_speed), 32'd1);
    check("start_score", 32'(bus.o_score), 32'h0);

    // First game: 45 points then a crash sets hiscore 0045.
    repeat (45) cyc(1, 1, 0);
    check("g1_score", 32'(bus.o_score), 32'h0045);
    cyc(0, 0, 1);
    check("g1_hit", 32'(bus.o_state), 32'd2);
    hit_phase(16'h0045, 16'h0045);

    // Restart from OVER.
    restart_cnt = 0;
    press_frame();
    check("over_restart_cnt", 32'(restart_cnt), 32'd1);
    check("over_to_run", 32'(bus.o_state), 32'd1);
    check("over_score_clr", 32'(bus.o_score), 32'h0);
    check("over_speed", 32'(bus.o_speed), 32'd1);
    check("over_hi_kept", 32'(bus.o_hiscore), 32'h0045);

    // 300 points, speed steps at 100/200/300.
    jump_cnt = 0;
    repeat (300) cyc(1, 1, 0);
    check("s300_score", 32'(bus.o_score), 32'h0300);
    check("s300_speed", 32'(bus.o_speed), 32'd4);
    check("s300_no_jump", 32'(jump_cnt), 32'd0);

    // A fresh press in RUN is a single jump.
    jump_cnt    = 0;
    restart_cnt = 0;
    press_frame();
    check("jump_cnt", 32'(jump_cnt), 32'd1);
    check("jump_no_restart", 32'(restart_cnt), 32'd0);
    check("jump_score", 32'(bus.o_score), 32'h0300);

    // Run up to 9999 (speed saturates), then wrap.
    repeat (9699) cyc(1, 1, 0);
    check("s9999_score", 32'(bus.o_score), 32'h9999);
    check("s9999_speed", 32'(bus.o_speed), 32'd7);
    cyc(1, 1, 0);
    check("wrap_score", 32'(bus.o_score), 32'h0000);
    check("wrap_speed", 32'(bus.o_speed), 32'd7);

    // 123 points, then collision coincident with a score tick.
    repeat (123) cyc(1, 1, 0);
    check("s123_score", 32'(bus.o_score), 32'h0123);
    cyc(1, 1, 1);
    check("col_score", 32'(bus.o_score), 32'h0123);
    check("col_state", 32'(bus.o_state), 32'd2);
    check("col_running", 32'(bus.o_running), 32'd0);
    hit_phase(16'h0123, 16'h0123);

    // Third game to 500, then reset mid-RUN with a pending press.
    press_frame();
    check("g3_state", 32'(bus.o_state), 32'd1);
    repeat (500) cyc(1, 1, 0);
    check("s500_score", 32'(bus.o_score), 32'h0500);
    bus.i_btn = 1'b0;
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    bus.i_btn = 1'b1;
    repeat (3) cyc(0, 0, 0);
    rst = 1'b1;
    bus.i_tick_60hz = 1'b1;
    bus.i_tick_20hz = 1'b1;
    @(negedge clk);
    check("rst_jump_low", 32'(bus.o_jump), 32'd0);
    check("rst_restart_low", 32'(bus.o_restart), 32'd0);
    @(posedge clk);
    #1;
    bus.i_tick_60hz = 1'b0;
    bus.i_tick_20hz = 1'b0;
    check("mid_rst_state", 32'(bus.o_state), 32'd0);
    check("mid_rst_score", 32'(bus.o_score), 32'h0);
    check("mid_rst_hiscore", 32'(bus.o_hiscore), 32'h0);
    check("mid_rst_speed", 32'(bus.o_speed), 32'd0);
    check("mid_rst_running", 32'(bus.o_running), 32'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
